sap1_loader: RTL and testbench

- Program loader for the SAP-1 16x8 RAM; the writer side of the RAM the CPU fetches from.
- Accepts a 16-byte program plus a checksum byte over a valid/ready byte stream and writes each byte to RAM addresses 0..15 in order.
- Reads the RAM back and verifies it against the checksum.
- Holds the CPU in clear for the whole load; releases it only after a successful verify.

---
 rtl/sap_pkg.sv | 30 +++
 rtl/loader_sum.sv | 41 ++++
 rtl/sap1_loader.sv | 191 +++++++++++++++++++
 tb/tb_sap1_loader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: RAM geometry and the program-loader state/error types.
package sap_pkg;

  // RAM geometry shared by the RAM, the MAR and the loader.
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [2:0] {
    L_IDLE   = 3'd0,
    L_LOAD   = 3'd1,
    L_CHECK  = 3'd2,
    L_VERIFY = 3'd3,
    L_DONE   = 3'd4,
    L_ERROR  = 3'd5
  } LOADER_STATE_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CKSUM  = 2'd1,
    ERR_VERIFY = 2'd2,
    ERR_ABORT  = 2'd3
  } LOADER_ERR_t;

  // States in which a load is in flight (start ignored, abort honoured).
  function automatic logic is_busy(LOADER_STATE_t s);
    return (s == L_LOAD) || (s == L_CHECK) || (s == L_VERIFY);
  endfunction

endpackage

// File: rtl/loader_sum.sv
// Modulo-2**W accumulator with clear and add-enable; clear has priority.
module loader_sum
  import sap_pkg::*;
#(
  parameter int W = RAM_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  // Next accumulator value: clear, add, or hold; the carry out is dropped.
  always_comb begin
    // NOTE: default first so that no branch leaves sum_d unassigned (no latch).
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register here samples pre-edge values.
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/sap1_loader.sv
// SAP-1 program loader: streams DEPTH bytes plus a checksum into the CPU RAM,
// reads the RAM back to verify it, and holds the CPU in clear until it passes.
module sap1_loader
  import sap_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,   // must equal 2**ADDR_W
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  localparam int                VCNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // VERIFY issues reads on counts 0..DEPTH-1 and decides on count DEPTH.
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(DEPTH);

  LOADER_STATE_t     state_q, state_d;
  LOADER_ERR_t       err_q, err_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [DATA_W-1:0] cksum_q, cksum_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              sum_clr, sum_en, vsum_clr, vsum_en;
  logic [DATA_W-1:0] sum_q, vsum_q;
  logic [DATA_W-1:0] ck_total, vsum_total;
  logic              accept;

  // Running sum of program bytes as they are accepted.
  loader_sum #(.W(DATA_W)) u_sum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sum_clr),
    .en_i   (sum_en),
    .data_i (in_data),
    .sum_o  (sum_q)
  );

  // Sum of the bytes read back from RAM during VERIFY.
  loader_sum #(.W(DATA_W)) u_vsum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (vsum_clr),
    .en_i   (vsum_en),
    .data_i (ram_rd_data),
    .sum_o  (vsum_q)
  );

  assign in_ready = (state_q == L_LOAD) || (state_q == L_CHECK);
  // Abort wins over a same-cycle byte: that byte is neither written nor summed.
  assign accept     = in_valid && in_ready && !abort;
  assign ck_total   = sum_q + in_data;
  // Includes the final readback byte, which arrives on the deciding cycle.
  assign vsum_total = vsum_q + ram_rd_data + cksum_q;

  // Next-state and datapath control for the load / check / verify sequence.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    vcnt_d    = vcnt_q;
    cksum_d   = cksum_q;
    ram_we_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sum_clr   = 1'b0;
    sum_en    = 1'b0;
    vsum_clr  = 1'b0;
    vsum_en   = 1'b0;

    unique case (state_q)
      L_IDLE, L_DONE, L_ERROR: begin
        if (start) begin
          state_d  = L_LOAD;
          err_d    = ERR_NONE;
          wr_ptr_d = '0;
          sum_clr  = 1'b1;
        end
      end

      L_LOAD: begin
        if (abort) begin
          state_d = L_ERROR;
          err_d   = ERR_ABORT;
        end else if (accept) begin
          ram_we_d  = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_data_d = in_data;
          sum_en    = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = L_CHECK;
          end
        end
      end

      L_CHECK: begin
        if (abort) begin
          state_d = L_ERROR;
          err_d   = ERR_ABORT;
        end else if (accept) begin
          if (ck_total == '0) begin
            state_d  = L_VERIFY;
            cksum_d  = in_data;
            vcnt_d   = '0;
            vsum_clr = 1'b1;
          end else begin
            state_d = L_ERROR;
            err_d   = ERR_CKSUM;
          end
        end
      end

      L_VERIFY: begin
        if (abort) begin
          state_d = L_ERROR;
          err_d   = ERR_ABORT;
          vcnt_d  = '0;
        end else begin
          // Read data trails its address by one cycle, so count 0 adds nothing.
          vsum_en = (vcnt_q != '0);
          vcnt_d  = vcnt_q + 1'b1;
          if (vcnt_q == VCNT_LAST) begin
            vcnt_d = '0;
            if (vsum_total == '0) begin
              state_d = L_DONE;
            end else begin
              state_d = L_ERROR;
              err_d   = ERR_VERIFY;
            end
          end
        end
      end

      default: begin
        state_d = L_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load and cancels writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= L_IDLE;
      err_q     <= ERR_NONE;
      wr_ptr_q  <= '0;
      vcnt_q    <= '0;
      cksum_q   <= '0;
      ram_we_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      vcnt_q    <= vcnt_d;
      cksum_q   <= cksum_d;
      ram_we_q  <= ram_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = vcnt_q[ADDR_W-1:0];
  assign busy        = is_busy(state_q);
  assign cpu_hold    = busy || (state_q == L_ERROR);
  assign done        = (state_q == L_DONE);
  assign err_code    = (state_q == L_ERROR) ? err_q : ERR_NONE;

endmodule

// File: tb/tb_sap1_loader.sv
// Self-checking bench for sap1_loader: a behavioural RAM plus an arithmetic
// model of the expected outcome (checksum / readback / timing) per program.
module tb_sap1_loader;

  typedef logic [7:0] prog_t [16];
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_we, cpu_hold, busy, done;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  wr_t        wr_log[$];
  bit         corrupt7 = 1'b0;

  always #5 clk = ~clk;

  sap1_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ram_we      (ram_we),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code)
  );

  // RAM model: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_log.push_back('{ram_wr_addr, ram_wr_data});
    end
    ram_rd_data <= (corrupt7 && ram_rd_addr == 4'd7) ? 8'h00 : mem[ram_rd_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int exp_err(input prog_t p, input logic [7:0] c, input bit corrupt);
    int s = 0;
    int v = 0;
    for (int i = 0; i < 16; i++) begin
      s += int'(p[i]);
      v += (corrupt && i == 7) ? 0 : int'(p[i]);
    end
    if ((s + int'(c)) % 256 != 0) return 1;
    if ((v + int'(c)) % 256 != 0) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] good_c(input prog_t p);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(p[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  function automatic prog_t rand_prog();
    prog_t p;
    for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
    return p;
  endfunction

  function automatic prog_t seq_prog();
    prog_t p;
    for (int i = 0; i < 16; i++) p[i] = 8'(i + 1);
    return p;
  endfunction

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte: in_ready=%0b, required 1 within 32 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_prog(input prog_t p, input logic [7:0] c, input bit gaps);
    wr_log.delete();
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(p[i]);
    end
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    send_byte(c);
  endtask

  // Counts negedges until busy drops; hold_last is cpu_hold on the last busy cycle.
  task automatic wait_idle(output int n, output logic hold_last);
    n = 0;
    hold_last = cpu_hold;
    while (busy && n < 64) begin
      hold_last = cpu_hold;
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, ram_we, cpu_hold, busy, done, err_code} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {in_ready, ram_we, cpu_hold, busy, done, err_code});
    end
    checks++;
    if ({ram_wr_addr, ram_wr_data, ram_rd_addr} !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h, required 0000", {ram_wr_addr, ram_wr_data, ram_rd_addr});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    prog_t p;
    int n;
    logic h;
    for (int t = 0; t < 2; t++) begin
      p = (t == 0) ? seq_prog() : rand_prog();
      run_prog(p, (t == 0) ? 8'h78 : good_c(p), t == 1);
      wait_idle(n, h);
      checks++;
      if (n != 17) begin
        errors++; $display("FAIL good_verify_len: got %0d cycles, required 17", n);
      end
      checks++;
      if (done !== 1'b1 || err_code !== 2'd0) begin
        errors++; $display("FAIL good_done: done=%0b err=%0d, required 1/0", done, err_code);
      end
      checks++;
      if (cpu_hold !== 1'b0 || h !== 1'b1) begin
        errors++; $display("FAIL good_hold: before=%0b at_done=%0b, required 1/0", h, cpu_hold);
      end
      checks++;
      if (wr_log.size() != 16) begin
        errors++; $display("FAIL good_wr_count: got %0d, required 16", wr_log.size());
      end
      for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
        checks++;
        if (wr_log[i].a !== 4'(i) || wr_log[i].d !== p[i] || mem[i] !== p[i]) begin
          errors++;
          $display("FAIL good_write[%0d]: addr=%0d data=%h mem=%h, required %0d/%h",
                   i, wr_log[i].a, wr_log[i].d, mem[i], i, p[i]);
        end
      end
    end
  endtask

  task automatic test_cksum_err();
    int n;
    logic h;
    run_prog(seq_prog(), 8'h79, 1'b0);
    wait_idle(n, h);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL cksum_no_verify: got %0d busy cycles after C, required 0", n);
    end
    checks++;
    if (err_code !== 2'd1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL cksum_err: err=%0d hold=%0b done=%0b, required 1/1/0", err_code, cpu_hold, done);
    end
  endtask

  task automatic test_verify_err();
    int n;
    logic h;
    prog_t p;
    for (int t = 0; t < 2; t++) begin
      p = (t == 0) ? seq_prog() : rand_prog();
      if (p[7] == 8'h00) p[7] = 8'h5a;
      corrupt7 = 1'b1;
      run_prog(p, good_c(p), t == 1);
      wait_idle(n, h);
      corrupt7 = 1'b0;
      checks++;
      if (n != 17) begin
        errors++; $display("FAIL verify_err_len: got %0d cycles, required 17", n);
      end
      checks++;
      if (err_code !== 2'(exp_err(p, good_c(p), 1'b1)) || cpu_hold !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL verify_err: err=%0d hold=%0b done=%0b, required 2/1/0", err_code, cpu_hold, done);
      end
    end
  endtask

  task automatic test_gapped();
    prog_t p;
    int n;
    logic h;
    p = rand_prog();
    wr_log.delete();
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = p[i];
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || ram_wr_addr !== 4'(i) || ram_wr_data !== p[i]) begin
        errors++;
        $display("FAIL gap_write[%0d]: we=%0b addr=%0d data=%h, required 1/%0d/%h",
                 i, ram_we, ram_wr_addr, ram_wr_data, i, p[i]);
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (i == 8) start = 1'b1;   // start while busy must be ignored
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (ram_we !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL gap_idle[%0d]: we=%0b busy=%0b, required 0/1", i, ram_we, busy);
      end
    end
    send_byte(good_c(p));
    wait_idle(n, h);
    checks++;
    if (done !== 1'b1 || n != 17) begin
      errors++; $display("FAIL gap_done: done=%0b len=%0d, required 1/17", done, n);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== p[i]) begin
        errors++; $display("FAIL gap_mem[%0d]: got %h, required %h", i, mem[i], p[i]);
      end
    end
  endtask

  task automatic test_abort();
    prog_t p;
    int n;
    logic h;
    p = rand_prog();
    wr_log.delete();
    start_pulse();
    for (int i = 0; i < 5; i++) send_byte(p[i]);
    in_valid = 1'b1;
    in_data  = p[5];
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (err_code !== 2'd3 || busy !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_err: err=%0d busy=%0b hold=%0b rdy=%0b, required 3/0/1/0",
               err_code, busy, cpu_hold, in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_log.size() != 5) begin
      errors++; $display("FAIL abort_wr_count: got %0d, required 5", wr_log.size());
    end
    abort = 1'b1;                 // abort in ERROR: no effect
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (err_code !== 2'd3) begin
      errors++; $display("FAIL abort_in_error: err=%0d, required 3", err_code);
    end
    p = rand_prog();
    run_prog(p, good_c(p), 1'b0);
    wait_idle(n, h);
    checks++;
    if (done !== 1'b1 || err_code !== 2'd0 || wr_log.size() != 16) begin
      errors++;
      $display("FAIL abort_recover: done=%0b err=%0d writes=%0d, required 1/0/16",
               done, err_code, wr_log.size());
    end
    abort = 1'b1;                 // abort in DONE: no effect
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL abort_in_done: done=%0b, required 1", done);
    end
    start = 1'b1;                 // start and abort together: start wins
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL start_over_abort: busy=%0b rdy=%0b err=%0d, required 1/1/0", busy, in_ready, err_code);
    end
    for (int i = 0; i < 16; i++) send_byte(p[i]);
    send_byte(good_c(p));
    repeat (3) @(negedge clk);
    abort = 1'b1;                 // abort during VERIFY
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (err_code !== 2'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_verify: err=%0d busy=%0b, required 3/0", err_code, busy);
    end
  endtask

  task automatic test_reset_verify();
    prog_t p;
    p = rand_prog();
    run_prog(p, good_c(p), 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pre_verify: busy=%0b rdy=%0b, required 1/0", busy, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_hold, busy, done, err_code, ram_we, in_ready} !== 7'b0) begin
      errors++;
      $display("FAIL rst_in_verify: hold/busy/done/err/we/rdy=%b, required 0000000",
               {cpu_hold, busy, done, err_code, ram_we, in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_stays_idle: busy=%0b done=%0b, required 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    prog_t p;
    logic [7:0] c;
    int e, n;
    logic h;
    bit cor;
    for (int t = 0; t < 6; t++) begin
      p   = rand_prog();
      c   = ($urandom_range(0, 1) == 1) ? good_c(p) : 8'($urandom);
      cor = ($urandom_range(0, 2) == 0);
      e   = exp_err(p, c, cor);
      corrupt7 = cor;
      run_prog(p, c, 1'b1);
      wait_idle(n, h);
      corrupt7 = 1'b0;
      checks++;
      if (err_code !== 2'(e) || done !== (e == 0) || n != ((e == 1) ? 0 : 17)) begin
        errors++;
        $display("FAIL b2b[%0d]: err=%0d done=%0b len=%0d, required %0d/%0b/%0d",
                 t, err_code, done, n, e, e == 0, (e == 1) ? 0 : 17);
      end
      checks++;
      if (wr_log.size() != 16) begin
        errors++; $display("FAIL b2b_wr_count[%0d]: got %0d, required 16", t, wr_log.size());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_load();
    test_cksum_err();
    test_verify_err();
    test_gapped();
    test_abort();
    test_reset_verify();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
